usb_line_state: RTL and testbench

//  Receive front end between the USB PHY pins and the protocol blocks. It synchronises D+/D-

---
 rtl/usb_line_state.sv | 128 ++++++++++++
 tb/tb_usb_line_state.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_line_state.sv
// usb_line_state: USB receive front end.
// Synchronises D+/D- into clk and decodes J/K/SE0/SE1 for the selected speed.
// Glitch-filters the decoded state and drives a registered se0 for the reset detector.
// Tracks bus suspend (idle J) and flags resume (K accepted while suspended).
module usb_line_state #(
    parameter int FILTER_LEN = 2,
    parameter int SUSP_FS    = 144000,
    parameter int SUSP_LS    = 18000,
    parameter int CNT_W      = 18
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       dp,
    input  logic       dm,
    input  logic       usb_full_speed,
    output logic [1:0] d_sync,
    output logic [1:0] line_state,
    output logic       se0,
    output logic       suspend,
    output logic       resume
);

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_t;

    // Filter counter only has to reach FILTER_LEN-1.
    localparam int                FCNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  ILIM_FS  = CNT_W'(SUSP_FS - 1);
    localparam logic [CNT_W-1:0]  ILIM_LS  = CNT_W'(SUSP_LS - 1);

    logic [1:0]        s1, s2;
    line_t             dec;
    line_t             cand_q, cand_d;
    line_t             ls_q, ls_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d, ilim;
    logic              susp_q, susp_d;
    logic              se0_q;
    logic              resume_q, resume_d;

    // Two-flop synchroniser for the asynchronous pin pair.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make s2 take the old s1, forming a real two-stage chain.
            s1 <= {dp, dm};
            s2 <= s1;
        end
    end

    // Speed-dependent decode; J and K swap meaning between full and low speed.
    always_comb begin
        dec = LS_SE0;
        case (s2)
            2'b00:   dec = LS_SE0;
            2'b11:   dec = LS_SE1;
            2'b10:   dec = usb_full_speed ? LS_J : LS_K;
            default: dec = usb_full_speed ? LS_K : LS_J;
        endcase
    end

    // Glitch filter: a candidate is accepted once it has been seen FILTER_LEN+1 times in a row.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latch).
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        ls_d   = ls_q;
        if (dec != cand_q) begin
            cand_d = dec;
            fcnt_d = '0;
        end else if (fcnt_q != FCNT_MAX) begin
            fcnt_d = fcnt_q + 1'b1;
        end else begin
            ls_d = cand_q;
        end
    end

    // Idle-J counter toward suspend, and resume detection on the filtered state.
    always_comb begin
        ilim   = usb_full_speed ? ILIM_FS : ILIM_LS;
        icnt_d = icnt_q;
        susp_d = susp_q;
        if (ls_q != LS_J) begin
            icnt_d = '0;
            susp_d = 1'b0;
        end else if (icnt_q < ilim) begin
            icnt_d = icnt_q + 1'b1;
        end else begin
            susp_d = 1'b1;
        end
        resume_d = (ls_d == LS_K) && (ls_q != LS_K) && susp_q;
    end

    // State registers; se0 and resume are registered alongside line_state.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cand_q   <= LS_J;
            fcnt_q   <= '0;
            ls_q     <= LS_J;
            se0_q    <= 1'b0;
            icnt_q   <= '0;
            susp_q   <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            fcnt_q   <= fcnt_d;
            ls_q     <= ls_d;
            se0_q    <= (ls_d == LS_SE0);
            icnt_q   <= icnt_d;
            susp_q   <= susp_d;
            resume_q <= resume_d;
        end
    end

    assign d_sync     = s2;
    assign line_state = ls_q;
    assign se0        = se0_q;
    assign suspend    = susp_q;
    assign resume     = resume_q;

endmodule

// File: tb/tb_usb_line_state.sv
// tb_usb_line_state: self-checking bench for usb_line_state.
// A run-length model predicts the outputs of every edge into a queue; each
// tick pops and compares. A segment table and hand sequences add explicit checks.
module tb_usb_line_state;

    localparam int F    = 2;
    localparam int SFS  = 20;
    localparam int SLS  = 12;
    localparam int NVEC = 16;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       dp, dm;
    logic       usb_full_speed;
    logic [1:0] d_sync, line_state;
    logic       se0, suspend, resume;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] d_sync;
        logic [1:0] ls;
        logic       se0;
        logic       susp;
        logic       res;
    } obs_t;

    typedef struct {
        logic [1:0] pins;
        logic       fs;
        int         len;
        logic [1:0] exp_ls;
        logic       exp_se0;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs [0:NVEC-1];

    // Reference model state
    logic [1:0] m_p0, m_p1;
    logic [1:0] m_hist[$];
    logic [1:0] m_ls;
    int         m_jcnt;
    logic       m_susp;

    usb_line_state #(
        .FILTER_LEN(F),
        .SUSP_FS   (SFS),
        .SUSP_LS   (SLS),
        .CNT_W     (18)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .dp            (dp),
        .dm            (dm),
        .usb_full_speed(usb_full_speed),
        .d_sync        (d_sync),
        .line_state    (line_state),
        .se0           (se0),
        .suspend       (suspend),
        .resume        (resume)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] tb_decode(input logic [1:0] pins, input logic fs);
        case (pins)
            2'b00:   return 2'b00;
            2'b11:   return 2'b11;
            2'b10:   return fs ? 2'b01 : 2'b10;
            default: return fs ? 2'b10 : 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_p0   = 2'b00;
        m_p1   = 2'b00;
        m_hist = {};
        m_hist.push_back(2'b01);
        m_ls   = 2'b01;
        m_jcnt = 0;
        m_susp = 1'b0;
    endtask

    // Predict the outputs after the coming edge from the inputs present now.
    task automatic model_step();
        logic [1:0] smp, new_ls;
        logic       new_susp, res;
        bit         all_eq;
        int         lim;
        obs_t       e;
        smp  = tb_decode(m_p1, usb_full_speed);
        m_p1 = m_p0;
        m_p0 = {dp, dm};
        m_hist.push_back(smp);
        if (m_hist.size() > F + 1) void'(m_hist.pop_front());
        new_ls = m_ls;
        if (m_hist.size() == F + 1) begin
            all_eq = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != smp) all_eq = 1'b0;
            if (all_eq) new_ls = smp;
        end
        lim = usb_full_speed ? SFS : SLS;
        if (m_ls != 2'b01) begin
            m_jcnt   = 0;
            new_susp = 1'b0;
        end else begin
            if (m_jcnt < 1000000) m_jcnt++;
            new_susp = (m_jcnt >= lim) ? 1'b1 : m_susp;
        end
        res = (new_ls == 2'b10) && (m_ls != 2'b10) && m_susp;
        e.d_sync = m_p1;
        e.ls     = new_ls;
        e.se0    = (new_ls == 2'b00);
        e.susp   = new_susp;
        e.res    = res;
        sb_q.push_back(e);
        m_ls   = new_ls;
        m_susp = new_susp;
    endtask

    // One clock: predict, let the edge happen, compare, return to the falling edge.
    task automatic tick();
        obs_t a, e;
        model_step();
        @(posedge clk);
        #1;
        a.d_sync = d_sync;
        a.ls     = line_state;
        a.se0    = se0;
        a.susp   = suspend;
        a.res    = resume;
        e = sb_q.pop_front();
        check("scoreboard", 8'(a), 8'(e));
        @(negedge clk);
    endtask

    task automatic set_pins(input logic [1:0] p);
        {dp, dm} = p;
    endtask

    task automatic run_until_suspend(input int budget, output int n);
        n = 0;
        while (!suspend && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic run_until_ls(input logic [1:0] v, input int budget, output int n);
        n = 0;
        while (line_state != v && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ls"},      8'(line_state), 8'h01);
        check({tag, "_se0"},     8'(se0),        8'h00);
        check({tag, "_suspend"}, 8'(suspend),    8'h00);
        check({tag, "_resume"},  8'(resume),     8'h00);
        check({tag, "_d_sync"},  8'(d_sync),     8'h00);
    endtask

    initial begin
        int n, cnt, first, pulses, res_idx, bad;

        // {pins, fs, cycles, line_state at end, se0 at end}
        vecs[0]  = '{2'b00, 1'b1, 10, 2'b00, 1'b1};
        vecs[1]  = '{2'b10, 1'b1, 10, 2'b01, 1'b0};
        vecs[2]  = '{2'b00, 1'b1,  2, 2'b01, 1'b0};
        vecs[3]  = '{2'b10, 1'b1,  6, 2'b01, 1'b0};
        vecs[4]  = '{2'b00, 1'b1,  3, 2'b01, 1'b0};
        vecs[5]  = '{2'b10, 1'b1,  2, 2'b00, 1'b1};
        vecs[6]  = '{2'b10, 1'b1,  8, 2'b01, 1'b0};
        vecs[7]  = '{2'b01, 1'b0,  8, 2'b01, 1'b0};
        vecs[8]  = '{2'b10, 1'b0,  8, 2'b10, 1'b0};
        vecs[9]  = '{2'b01, 1'b0,  8, 2'b01, 1'b0};
        vecs[10] = '{2'b10, 1'b0,  8, 2'b10, 1'b0};
        vecs[11] = '{2'b10, 1'b1,  2, 2'b10, 1'b0};
        vecs[12] = '{2'b10, 1'b1,  1, 2'b01, 1'b0};
        vecs[13] = '{2'b10, 1'b0,  2, 2'b01, 1'b0};
        vecs[14] = '{2'b10, 1'b0,  1, 2'b10, 1'b0};
        vecs[15] = '{2'b10, 1'b1,  6, 2'b01, 1'b0};

        // Reset state
        reset_i        = 1'b1;
        usb_full_speed = 1'b1;
        set_pins(2'b10);
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_i = 1'b0;

        // Reset release: the 00 held in the synchroniser must not reach se0
        for (int i = 0; i < 8; i++) begin
            tick();
            check("release_no_se0", 8'(se0), 8'h00);
        end

        // Segment table
        for (int v = 0; v < NVEC; v++) begin
            usb_full_speed = vecs[v].fs;
            set_pins(vecs[v].pins);
            repeat (vecs[v].len) tick();
            check($sformatf("vec%0d_ls", v),  8'(line_state), 8'(vecs[v].exp_ls));
            check($sformatf("vec%0d_se0", v), 8'(se0),        8'(vecs[v].exp_se0));
        end

        // SE0 held 10 cycles: se0 rises on the 5th edge and falls 5 edges after J returns
        set_pins(2'b00);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("t1_rise_%0d", i), 8'(se0), 8'(i >= 5));
        end
        set_pins(2'b10);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("t1_fall_%0d", i), 8'(se0), 8'(i < 5));
        end
        repeat (2) tick();

        // 2-cycle SE0 glitch is rejected
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            set_pins(i < 2 ? 2'b00 : 2'b10);
            tick();
            if (se0 || line_state != 2'b01) bad++;
        end
        check("t2_short_glitch", 8'(bad), 8'h00);

        // 3-cycle SE0 is accepted for exactly 3 cycles
        cnt   = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            set_pins(i < 3 ? 2'b00 : 2'b10);
            tick();
            if (se0) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("t2_width",     8'(cnt),   8'd3);
        check("t2_first_se0", 8'(first), 8'd4);

        // Suspend exactly SUSP_FS edges after line_state becomes J
        set_pins(2'b00);
        repeat (8) tick();
        set_pins(2'b10);
        run_until_ls(2'b01, 20, n);
        check("t4_j_reached", 8'(line_state), 8'h01);
        run_until_suspend(40, n);
        check("t4_susp_delay", 8'(n), 8'(SFS));

        // K for 5 cycles: one resume pulse, suspend drops on the next edge
        pulses  = 0;
        res_idx = -1;
        for (int i = 0; i < 20; i++) begin
            set_pins(i < 5 ? 2'b01 : 2'b10);
            tick();
            if (res_idx >= 0 && i == res_idx + 1) check("t4_susp_drop", 8'(suspend), 8'h00);
            if (resume) begin
                pulses++;
                res_idx = i;
                check("t4_res_with_k",    8'(line_state), 8'h02);
                check("t4_susp_at_pulse", 8'(suspend),    8'h01);
            end
        end
        check("t4_pulses",  8'(pulses),  8'd1);
        check("t4_res_idx", 8'(res_idx), 8'd4);

        // Suspended then SE0: suspend clears, no resume, se0 reported
        set_pins(2'b10);
        run_until_suspend(60, n);
        check("t5_susp_a", 8'(suspend), 8'h01);
        set_pins(2'b00);
        pulses = 0;
        repeat (8) begin
            tick();
            if (resume) pulses++;
        end
        check("t5_se0_no_res",  8'(pulses),  8'd0);
        check("t5_se0_susp",    8'(suspend), 8'h00);
        check("t5_se0_flag",    8'(se0),     8'h01);

        // Suspended then SE1: suspend clears, no resume
        set_pins(2'b10);
        run_until_suspend(60, n);
        check("t5_susp_b", 8'(suspend), 8'h01);
        set_pins(2'b11);
        pulses = 0;
        repeat (8) begin
            tick();
            if (resume) pulses++;
        end
        check("t5_se1_no_res", 8'(pulses),     8'd0);
        check("t5_se1_susp",   8'(suspend),    8'h00);
        check("t5_se1_ls",     8'(line_state), 8'h03);

        // Reset asserted mid-K between edges
        set_pins(2'b01);
        repeat (8) tick();
        check("t6_k_before", 8'(line_state), 8'h02);
        #2 reset_i = 1'b1;
        #1;
        check_reset_outputs("t6_midk");
        @(negedge clk);
        set_pins(2'b10);
        reset_i = 1'b0;
        model_reset();
        n   = 0;
        bad = 0;
        while (!suspend && n < 40) begin
            tick();
            n++;
            if (se0 || resume) bad++;
        end
        check("t6_restart_a", 8'(n),   8'(SFS));
        check("t6_clean_a",   8'(bad), 8'h00);

        // Reset asserted mid-suspend between edges
        #2 reset_i = 1'b1;
        #1;
        check_reset_outputs("t6_midsusp");
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        n   = 0;
        bad = 0;
        while (!suspend && n < 40) begin
            tick();
            n++;
            if (se0 || resume) bad++;
        end
        check("t6_restart_b", 8'(n),   8'(SFS));
        check("t6_clean_b",   8'(bad), 8'h00);

        // Speed change while suspended: J turns into K and resumes
        usb_full_speed = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick();
            if (resume) pulses++;
        end
        check("spd_resume", 8'(pulses), 8'd1);

        // Low-speed suspend limit
        set_pins(2'b01);
        run_until_ls(2'b01, 20, n);
        check("ls_j_reached", 8'(line_state), 8'h01);
        run_until_suspend(40, n);
        check("ls_susp_delay", 8'(n), 8'(SLS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
